// File: rtl/riscv_core_fetch_queue.sv
// In-order fetch queue between the imem port and Decode.
// Each entry carries the request PC and, once the response lands, the
// instruction word. Entries alive at a redirect are either dropped (already
// filled) or marked killed (still in flight), so late responses are discarded.
module riscv_core_fetch_queue #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h00080000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       imemreq_fire,
  input  logic [31:0]                imemreq_pc,
  output logic                       imemreq_rdy_Fhl,
  input  logic                       imemresp_val,
  input  logic [31:0]                imemresp_msg_data,
  input  logic                       squash,
  input  logic                       deq,
  output logic                       inst_val_Fhl,
  output logic [31:0]                inst_Fhl,
  output logic [31:0]                pc_Fhl,
  output logic [31:0]                pc_plus4_Fhl,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [DEPTH-1:0] filled_q, kill_q;
  logic [PW-1:0]    alloc_ptr_q, fill_ptr_q, head_ptr_q;
  logic [OW-1:0]    occ_q, pend_q;   // allocated entries / allocated-but-unfilled
  logic             err_q;

  logic             alloc, fill;
  logic [OW-1:0]    nfilled, free_cnt;
  logic [DEPTH-1:0] unf;
  logic [PW-1:0]    off [DEPTH];

  assign imemreq_rdy_Fhl = (occ_q < OW'(DEPTH));
  assign alloc           = imemreq_fire && imemreq_rdy_Fhl;
  assign fill            = imemresp_val && (pend_q != '0);
  assign inst_val_Fhl    = (occ_q != '0) && filled_q[head_ptr_q] && !kill_q[head_ptr_q];
  assign inst_Fhl        = inst_q[head_ptr_q];
  assign pc_Fhl          = pc_q[head_ptr_q];
  assign pc_plus4_Fhl    = pc_Fhl + 32'd4;
  assign occupancy       = occ_q;
  assign proto_err       = err_q;

  // Unfilled entries are the pend_q entries starting at fill_ptr.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      off[i] = PW'(i) - fill_ptr_q;
      unf[i] = ({1'b0, off[i]} < pend_q);
    end
  end

  // Entries freed this cycle. Killed entries are always an unfilled prefix
  // at the head, so a fill into a killed entry is always the head entry.
  // On squash the filled prefix goes, plus the entry filled this cycle,
  // which squash kills and which sits right behind that prefix.
  always_comb begin
    nfilled  = occ_q - pend_q;
    free_cnt = '0;
    if (squash)
      free_cnt = nfilled + OW'(fill);
    else if (fill && kill_q[fill_ptr_q])
      free_cnt = OW'(1);
    else if (deq && inst_val_Fhl)
      free_cnt = OW'(1);
  end

  // Pointer, counter and sticky error state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      occ_q       <= '0;
      pend_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      alloc_ptr_q <= alloc_ptr_q + PW'(alloc);
      fill_ptr_q  <= fill_ptr_q + PW'(fill);
      head_ptr_q  <= head_ptr_q + free_cnt[PW-1:0];
      occ_q       <= occ_q + OW'(alloc) - free_cnt;
      pend_q      <= pend_q + OW'(alloc) - OW'(fill);
      if ((imemreq_fire && !imemreq_rdy_Fhl) || (imemresp_val && !fill))
        err_q <= 1'b1;
    end
  end

  // Entry storage: kill on squash, fill on response, (re)initialise on alloc.
  // The alloc slot is never an unfilled entry, so the writes do not overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= RESET_VECTOR;
        inst_q[i] <= '0;
      end
      filled_q <= '0;
      kill_q   <= '0;
    end else begin
      if (squash) kill_q <= kill_q | unf;
      if (fill) begin
        inst_q[fill_ptr_q]   <= imemresp_msg_data;
        filled_q[fill_ptr_q] <= 1'b1;
      end
      if (alloc) begin
        pc_q[alloc_ptr_q]     <= imemreq_pc;
        filled_q[alloc_ptr_q] <= 1'b0;
        kill_q[alloc_ptr_q]   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_fetch_queue.sv
// Directed bench for the fetch queue; expected values are hand-computed.
module tb_riscv_core_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imemreq_fire = 1'b0;
  logic [31:0] imemreq_pc = '0;
  logic        imemreq_rdy_Fhl;
  logic        imemresp_val = 1'b0;
  logic [31:0] imemresp_msg_data = '0;
  logic        squash = 1'b0;
  logic        deq = 1'b0;
  logic        inst_val_Fhl;
  logic [31:0] inst_Fhl, pc_Fhl, pc_plus4_Fhl;
  logic [2:0]  occupancy;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  riscv_core_fetch_queue #(.DEPTH(4), .RESET_VECTOR(32'h00080000)) dut (
    .clk(clk), .reset(reset),
    .imemreq_fire(imemreq_fire), .imemreq_pc(imemreq_pc),
    .imemreq_rdy_Fhl(imemreq_rdy_Fhl),
    .imemresp_val(imemresp_val), .imemresp_msg_data(imemresp_msg_data),
    .squash(squash), .deq(deq),
    .inst_val_Fhl(inst_val_Fhl), .inst_Fhl(inst_Fhl),
    .pc_Fhl(pc_Fhl), .pc_plus4_Fhl(pc_plus4_Fhl),
    .occupancy(occupancy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; inputs are single-cycle pulses, cleared just after the edge.
  task automatic tick();
    @(posedge clk); #1;
    imemreq_fire = 1'b0; imemresp_val = 1'b0; squash = 1'b0; deq = 1'b0;
  endtask

  task automatic fire(input logic [31:0] pc);
    imemreq_fire = 1'b1; imemreq_pc = pc;
  endtask

  task automatic resp(input logic [31:0] d);
    imemresp_val = 1'b1; imemresp_msg_data = d;
  endtask

  initial begin
    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_occ",  32'(occupancy), 32'd0);
    chk("rst_rdy",  32'(imemreq_rdy_Fhl), 32'd1);
    chk("rst_val",  32'(inst_val_Fhl), 32'd0);
    chk("rst_inst", inst_Fhl, 32'd0);
    chk("rst_pc",   pc_Fhl, 32'h00080000);
    chk("rst_pc4",  pc_plus4_Fhl, 32'h00080004);
    chk("rst_err",  32'(proto_err), 32'd0);
    reset = 1'b1;

    // 1: two requests, responses one cycle apart, deq each
    fire(32'h80000); tick();
    chk("t1_occ1", 32'(occupancy), 32'd1);
    chk("t1_val0", 32'(inst_val_Fhl), 32'd0);
    fire(32'h80004); resp(32'h00000013); tick();
    chk("t1_val1", 32'(inst_val_Fhl), 32'd1);
    chk("t1_inst1", inst_Fhl, 32'h00000013);
    chk("t1_pc1",  pc_Fhl, 32'h80000);
    chk("t1_pc41", pc_plus4_Fhl, 32'h80004);
    chk("t1_occ2", 32'(occupancy), 32'd2);
    deq = 1'b1; resp(32'h00100093); tick();
    chk("t1_val2", 32'(inst_val_Fhl), 32'd1);
    chk("t1_inst2", inst_Fhl, 32'h00100093);
    chk("t1_pc2",  pc_Fhl, 32'h80004);
    chk("t1_pc42", pc_plus4_Fhl, 32'h80008);
    chk("t1_occ3", 32'(occupancy), 32'd1);
    deq = 1'b1; tick();
    chk("t1_occ4", 32'(occupancy), 32'd0);
    chk("t1_val3", 32'(inst_val_Fhl), 32'd0);

    // 2: fill the queue, then drain one
    for (int k = 0; k < 4; k++) begin
      chk("t2_rdy_pre", 32'(imemreq_rdy_Fhl), 32'd1);
      fire(32'h100 + 32'(4 * k)); tick();
    end
    chk("t2_rdy_full", 32'(imemreq_rdy_Fhl), 32'd0);
    chk("t2_occ_full", 32'(occupancy), 32'd4);
    resp(32'h0000AAAA); tick();
    chk("t2_val", 32'(inst_val_Fhl), 32'd1);
    chk("t2_pc",  pc_Fhl, 32'h100);
    chk("t2_rdy_still", 32'(imemreq_rdy_Fhl), 32'd0);
    deq = 1'b1; tick();
    chk("t2_occ3", 32'(occupancy), 32'd3);
    chk("t2_rdy_back", 32'(imemreq_rdy_Fhl), 32'd1);
    for (int k = 1; k < 4; k++) begin
      resp(32'hB0 + 32'(k)); tick();
      chk("t2_drain_pc", pc_Fhl, 32'h100 + 32'(4 * k));
      chk("t2_drain_inst", inst_Fhl, 32'hB0 + 32'(k));
      deq = 1'b1; tick();
    end
    chk("t2_occ0", 32'(occupancy), 32'd0);

    // 3: squash with one filled + two in flight, redirect issued same cycle
    fire(32'h80010); tick();
    fire(32'h80014); tick();
    fire(32'h80018); tick();
    resp(32'h11); tick();
    chk("t3_val_pre", 32'(inst_val_Fhl), 32'd1);
    chk("t3_occ_pre", 32'(occupancy), 32'd3);
    squash = 1'b1; fire(32'h80100); tick();
    chk("t3_occ_sq", 32'(occupancy), 32'd3);
    chk("t3_val_sq", 32'(inst_val_Fhl), 32'd0);
    resp(32'h22); tick();
    chk("t3_val_k1", 32'(inst_val_Fhl), 32'd0);
    chk("t3_occ_k1", 32'(occupancy), 32'd2);
    resp(32'h33); tick();
    chk("t3_val_k2", 32'(inst_val_Fhl), 32'd0);
    chk("t3_occ_k2", 32'(occupancy), 32'd1);
    resp(32'h44); tick();
    chk("t3_val_new", 32'(inst_val_Fhl), 32'd1);
    chk("t3_pc_new",  pc_Fhl, 32'h80100);
    chk("t3_inst_new", inst_Fhl, 32'h44);
    deq = 1'b1; tick();
    chk("t3_occ0", 32'(occupancy), 32'd0);

    // 4: squash + response + deq in one cycle
    fire(32'h200); tick();
    fire(32'h204); tick();
    fire(32'h208); tick();
    resp(32'h55); tick();
    chk("t4_val_pre", 32'(inst_val_Fhl), 32'd1);
    squash = 1'b1; resp(32'h66); deq = 1'b1; tick();
    chk("t4_occ", 32'(occupancy), 32'd1);
    chk("t4_val", 32'(inst_val_Fhl), 32'd0);
    resp(32'h77); tick();
    chk("t4_occ_end", 32'(occupancy), 32'd0);
    chk("t4_val_end", 32'(inst_val_Fhl), 32'd0);
    chk("t4_err", 32'(proto_err), 32'd0);

    // 5: pc+4 wraparound, then orphan response sets sticky error
    fire(32'hFFFFFFFC); tick();
    resp(32'h99); tick();
    chk("t5_val", 32'(inst_val_Fhl), 32'd1);
    chk("t5_pc",  pc_Fhl, 32'hFFFFFFFC);
    chk("t5_pc4", pc_plus4_Fhl, 32'h00000000);
    deq = 1'b1; tick();
    chk("t5_err_pre", 32'(proto_err), 32'd0);
    resp(32'hDEAD); tick();
    chk("t5_err", 32'(proto_err), 32'd1);
    chk("t5_occ", 32'(occupancy), 32'd0);
    chk("t5_val0", 32'(inst_val_Fhl), 32'd0);
    tick(); tick();
    chk("t5_err_sticky", 32'(proto_err), 32'd1);

    // 6: asynchronous reset mid-burst
    fire(32'h300); tick();
    fire(32'h304); resp(32'hAB); tick();
    chk("t6_val_pre", 32'(inst_val_Fhl), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("t6_val", 32'(inst_val_Fhl), 32'd0);
    chk("t6_occ", 32'(occupancy), 32'd0);
    chk("t6_rdy", 32'(imemreq_rdy_Fhl), 32'd1);
    chk("t6_pc",  pc_Fhl, 32'h00080000);
    chk("t6_err", 32'(proto_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_core_fetch_queue.md
Name: riscv_core_fetch_queue

Overview:
In-order instruction fetch queue between the instruction memory port and the Decode stage of the 7-stage RISCV core. It tags every issued imem request with its PC and captures the imem response data. It presents {inst, pc, pc+4} to Decode with a valid bit, and discards responses killed by a branch or jump redirect (squash). It replaces the direct pc_Fhl/pc_Dhl register path so that fetch can keep up to DEPTH requests in flight.

Parameters:
DEPTH  4  number of entries (in-flight plus buffered); power of two, >= 2
RESET_VECTOR  32'h00080000  PC driven on pc_Fhl while the queue is empty after reset

Ports:
clk  input  1  core clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (asserted when 0)
imemreq_fire  input  1  imem request accepted this cycle; allocates one entry
imemreq_pc  input  32  PC of the request issued this cycle
imemreq_rdy_Fhl  output  1  entry available; fetch may fire next request
imemresp_val  input  1  imem response valid this cycle
imemresp_msg_data  input  32  instruction word of the response
squash  input  1  redirect from X or D; kills all live entries
deq  input  1  Decode consumes the head entry (== inst_val_Fhl && !stall_Dhl)
inst_val_Fhl  output  1  head entry holds a returned, non-killed instruction
inst_Fhl  output  32  head instruction word
pc_Fhl  output  32  head PC
pc_plus4_Fhl  output  32  head PC + 4, modulo 2^32
occupancy  output  $clog2(DEPTH)+1  number of allocated entries
proto_err  output  1  sticky error flag

Behaviour:
- Storage: DEPTH entries, each holding pc[31:0], inst[31:0], filled bit and kill bit.
- Three pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH: alloc_ptr, fill_ptr, head_ptr.
- Reset (reset==0, asynchronous): all pointers 0, all filled and kill bits 0, occupancy 0, imemreq_rdy_Fhl 1, inst_val_Fhl 0, inst_Fhl 0, pc_Fhl RESET_VECTOR, pc_plus4_Fhl RESET_VECTOR+4, proto_err 0.
- Reset asserted mid-operation drops all entries immediately. Responses to requests issued before reset are not tracked. The fetch side must not issue requests until reset is released.
- Allocate: on imemreq_fire && imemreq_rdy_Fhl, write pc=imemreq_pc, filled=0, kill=0 at alloc_ptr, then advance alloc_ptr.
- Fill: on imemresp_val with at least one allocated, unfilled entry, write inst at fill_ptr, set filled=1, advance fill_ptr. Responses arrive strictly in request order.
- Latency: a response is visible on inst_val_Fhl the cycle after imemresp_val. There is no combinational bypass.
- Head: inst_val_Fhl = (occupancy != 0) && filled[head] && !kill[head]. Data outputs always reflect the head entry, and are don't-care when inst_val_Fhl is 0.
- Dequeue: on deq && inst_val_Fhl, free the head and advance head_ptr.
- Killed-entry retirement: a head entry with filled=1 and kill=1 is freed automatically in the same cycle it becomes filled, so it never reaches inst_val_Fhl.
- Squash:
  - Filled entries are freed immediately.
  - Unfilled entries get kill=1 and stay allocated until their response returns; that response is then discarded.
  - head_ptr advances past every freed entry.
- imemreq_rdy_Fhl = (registered occupancy < DEPTH). It does not depend combinationally on deq or squash in the same cycle.
- Simultaneous events:
  - squash + imemreq_fire: the new request is the redirect target and is NOT killed.
  - squash + imemresp_val: the response lands in a killed entry and is discarded.
  - squash + deq: deq is ignored.
  - deq + fill + alloc in one cycle: all three apply, and occupancy changes by alloc - free.
- Protocol errors: imemreq_fire while imemreq_rdy_Fhl==0, or imemresp_val with no unfilled entry. In either case the event is ignored and proto_err is set to 1 until reset.
- Arithmetic: pc_plus4_Fhl is a 32-bit wraparound add; 32'hFFFFFFFC gives 0.

Test Plan:
1. Release reset, fire requests at pc 0x80000 and 0x80004, return 0x00000013 then 0x00100093 one cycle apart, deq each → inst_val rises 1 cycle after each response; pc/pc_plus4 = 0x80000/0x80004, then 0x80004/0x80008.
2. DEPTH=4: fire 4 requests with no responses → imemreq_rdy_Fhl=0 and occupancy=4. Return 1 response and deq it → rdy returns to 1 the cycle after deq.
3. 3 requests outstanding, 1 filled and not dequeued, then squash and a request at 0x80100 in the same cycle → filled entry freed. The 2 following responses are discarded with inst_val=0. The third response appears with pc_Fhl=0x80100.
4. squash in the same cycle as imemresp_val and deq → response discarded, deq ignored, occupancy reflects only entries still pending.
5. Head pc 0xFFFFFFFC → pc_plus4_Fhl=0x00000000. imemresp_val with occupancy 0 → proto_err=1 and sticky until reset.
6. Drive reset=0 asynchronously mid-burst (not on a clk edge) → inst_val=0, occupancy=0, rdy=1 and pc_Fhl=0x00080000 immediately, without waiting for a clock edge.
